// File: rtl/history_shift_register_bank.sv
// Depth-entry history of NrOfBits-wide words with shift/rotate advance, random-access
// tri-stateable readout, newest/oldest taps, saturating occupancy count and change pulse.
module history_shift_register_bank #(
    parameter  int NrOfBits = 8,
    parameter  int Depth    = 8,
    localparam int AW       = $clog2(Depth),
    localparam int CW       = $clog2(Depth + 1)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic [1:0]          Mode,
    input  logic [NrOfBits-1:0] D,
    input  logic                clr,
    input  logic                pre,
    input  logic [AW-1:0]       RdAddr,
    input  logic                cs,
    output logic [NrOfBits-1:0] Q,
    output logic [NrOfBits-1:0] Newest,
    output logic [NrOfBits-1:0] Oldest,
    output logic [CW-1:0]       Count,
    output logic                Full,
    output logic                Changed
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(Depth);

    logic [NrOfBits-1:0] entries_q [Depth];
    logic [NrOfBits-1:0] entries_d [Depth];
    logic [CW-1:0]       count_q, count_d;
    logic                changed_q, changed_d;
    logic                advance;
    mode_e               mode;
    logic [NrOfBits-1:0] rd_data;

    assign advance = ClockEnable & Tick;
    assign mode    = mode_e'(Mode);

    // Next-state: clr beats pre beats advance; anything but a shift drops Changed.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latches).
        entries_d = entries_q;
        count_d   = count_q;
        changed_d = 1'b0;

        if (clr) begin
            for (int i = 0; i < Depth; i++) entries_d[i] = '0;
            count_d = '0;
        end else if (pre) begin
            for (int i = 0; i < Depth; i++) entries_d[i] = '1;
            count_d = DEPTH_CNT;
        end else if (advance) begin
            case (mode)
                MODE_SHIFT: begin
                    entries_d[0] = D;
                    for (int i = 1; i < Depth; i++) entries_d[i] = entries_q[i-1];
                    if (count_q != DEPTH_CNT) count_d = count_q + CW'(1);
                    changed_d = (D != entries_q[0]);
                end
                MODE_ROTATE: begin
                    entries_d[0] = entries_q[Depth-1];
                    for (int i = 1; i < Depth; i++) entries_d[i] = entries_q[i-1];
                end
                default: ;
            endcase
        end
    end

    // NOTE: the history is register-based and must read as zero straight out of reset,
    // so every entry is on the asynchronous reset, unlike a RAM-backed memory.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            // NOTE: sequential state uses non-blocking assignments so all entries shift from old values.
            entries_q <= '{default: '0};
            count_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            changed_q <= changed_d;
        end
    end

    // Indices at or beyond Depth (non-power-of-two Depth) read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < Depth; i++) begin
            if (RdAddr == AW'(i)) rd_data = entries_q[i];
        end
    end

    assign Q       = cs ? {NrOfBits{1'bz}} : rd_data;
    assign Newest  = entries_q[0];
    assign Oldest  = entries_q[Depth-1];
    assign Count   = count_q;
    assign Full    = (count_q == DEPTH_CNT);
    assign Changed = changed_q;

endmodule

// File: tb/tb_history_shift_register_bank.sv
// Self-checking bench: two instances (Depth 8 and Depth 6) compared every cycle against an
// array-based history model, plus literal checks from the worked examples.
module tb_history_shift_register_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce, tick, clr, pre, cs;
    logic [1:0] mode;
    logic [7:0] d;
    logic [2:0] rd_addr;

    wire  [7:0] q8, newest8, oldest8;
    wire  [3:0] count8;
    wire        full8, changed8;
    wire  [7:0] q6, newest6, oldest6;
    wire  [2:0] count6;
    wire        full6, changed6;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    // Behavioural history model per instance (index 0 = Depth 8, 1 = Depth 6).
    int         dep [2] = '{8, 6};
    logic [7:0] me  [2][64];
    int         mcnt[2];
    bit         mchg[2];

    always #5 clk = ~clk;

    history_shift_register_bank #(.NrOfBits(8), .Depth(8)) dut8 (
        .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Tick(tick), .Mode(mode), .D(d),
        .clr(clr), .pre(pre), .RdAddr(rd_addr), .cs(cs), .Q(q8), .Newest(newest8),
        .Oldest(oldest8), .Count(count8), .Full(full8), .Changed(changed8)
    );

    history_shift_register_bank #(.NrOfBits(8), .Depth(6)) dut6 (
        .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Tick(tick), .Mode(mode), .D(d),
        .clr(clr), .pre(pre), .RdAddr(rd_addr), .cs(cs), .Q(q6), .Newest(newest6),
        .Oldest(oldest6), .Count(count6), .Full(full6), .Changed(changed6)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_hiz(input string name, input logic [7:0] act);
        total++;
        if (act === 8'hzz || act === 8'h00) passed++;
        else $display("FAIL %s: got %0h expected hi-z (t=%0t)", name, act, $time);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) me[k][i] = 8'h00;
            mcnt[k] = 0;
            mchg[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int         n;
        logic [7:0] last;
        n = dep[k];
        mchg[k] = 1'b0;
        if (clr) begin
            for (int i = 0; i < n; i++) me[k][i] = 8'h00;
            mcnt[k] = 0;
        end else if (pre) begin
            for (int i = 0; i < n; i++) me[k][i] = 8'hFF;
            mcnt[k] = n;
        end else if (ce && tick && mode == 2'b01) begin
            mchg[k] = (d != me[k][0]);
            for (int i = n - 1; i > 0; i--) me[k][i] = me[k][i-1];
            me[k][0] = d;
            mcnt[k] = (mcnt[k] + 1 > n) ? n : mcnt[k] + 1;
        end else if (ce && tick && mode == 2'b10) begin
            last = me[k][n-1];
            for (int i = n - 1; i > 0; i--) me[k][i] = me[k][i-1];
            me[k][0] = last;
        end
    endtask

    initial model_clear();

    always @(posedge clk) begin
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge rst_n) model_clear();

    function automatic logic [7:0] model_q(input int k, input logic [2:0] a);
        return (int'(a) < dep[k]) ? me[k][a] : 8'h00;
    endfunction

    // One comparison point per cycle, mid-way between rising edges.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("newest8",  newest8,  me[0][0]);
            check("oldest8",  oldest8,  me[0][7]);
            check("count8",   count8,   mcnt[0]);
            check("full8",    full8,    mcnt[0] == 8);
            check("changed8", changed8, mchg[0]);
            check("newest6",  newest6,  me[1][0]);
            check("oldest6",  oldest6,  me[1][5]);
            check("count6",   count6,   mcnt[1]);
            check("full6",    full6,    mcnt[1] == 6);
            check("changed6", changed6, mchg[1]);
            if (cs) begin
                check_hiz("q8_cs", q8);
                check_hiz("q6_cs", q6);
            end else begin
                check("q8", q8, model_q(0, rd_addr));
                check("q6", q6, model_q(1, rd_addr));
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic p, input logic e, input logic t,
                          input logic [1:0] m, input logic [7:0] dv);
        clr = c; pre = p; ce = e; tick = t; mode = m; d = dv;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 2'b00, 8'h00);
        rd_addr = 3'd0;
        cs = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("reset_count", count8, 0);
        check("reset_q", q8, 8'h00);
        step_clk();
        step_clk();
        rst_n = 1'b1;

        // Ten shifts of 1..10: count saturates at 8, Full on the 8th edge.
        for (int i = 1; i <= 10; i++) begin
            set_in(0, 0, 1, 1, 2'b01, 8'(i));
            step_clk();
            check("fill_count", count8, (i > 8) ? 8 : i);
            check("fill_full", full8, i >= 8);
        end
        set_in(0, 0, 1, 1, 2'b00, 8'h00);
        rd_addr = 3'd2;
        step_clk();
        check("fill_newest", newest8, 8'd10);
        check("fill_oldest", oldest8, 8'd3);
        check("fill_q2", q8, 8'd8);

        // Change-detect pulses: 5 vs 0, 5 vs 5, 7 vs 5, then hold.
        set_in(1, 0, 0, 0, 2'b00, 8'h00);
        step_clk();
        set_in(0, 0, 1, 1, 2'b01, 8'd5);
        step_clk();
        check("chg_5a", changed8, 1'b1);
        step_clk();
        check("chg_5b", changed8, 1'b0);
        set_in(0, 0, 1, 1, 2'b01, 8'd7);
        step_clk();
        check("chg_7", changed8, 1'b1);
        set_in(0, 0, 1, 1, 2'b00, 8'd9);
        step_clk();
        check("chg_hold", changed8, 1'b0);

        // Load 1..8 then rotate three times.
        set_in(1, 0, 0, 0, 2'b00, 8'h00);
        step_clk();
        for (int i = 1; i <= 8; i++) begin
            set_in(0, 0, 1, 1, 2'b01, 8'(i));
            step_clk();
        end
        check("rot_pre_newest", newest8, 8'd8);
        set_in(0, 0, 1, 1, 2'b10, 8'h55);
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check("rot_changed", changed8, 1'b0);
        end
        check("rot_newest", newest8, 8'd3);
        check("rot_oldest", oldest8, 8'd4);
        check("rot_count", count8, 8);

        // Overlaps and gating.
        set_in(0, 1, 1, 1, 2'b01, 8'h12);
        step_clk();
        rd_addr = 3'd4;
        #1;
        check("pre_newest", newest8, 8'hFF);
        check("pre_q4", q8, 8'hFF);
        check("pre_count", count8, 8);
        check("pre_changed", changed8, 1'b0);
        set_in(1, 1, 1, 1, 2'b01, 8'h34);
        step_clk();
        check("clrpre_oldest", oldest8, 8'h00);
        check("clrpre_count", count8, 0);
        set_in(0, 0, 0, 1, 2'b01, 8'h77);
        step_clk();
        check("gated_newest", newest8, 8'h00);
        check("gated_count", count8, 0);

        // Tri-state readout and out-of-range index on the Depth-6 instance.
        set_in(0, 0, 1, 1, 2'b01, 8'hA5);
        step_clk();
        set_in(0, 0, 0, 0, 2'b00, 8'h00);
        rd_addr = 3'd0;
        cs = 1'b1;
        #1;
        check_hiz("cs_q8", q8);
        check("cs_newest", newest8, 8'hA5);
        cs = 1'b0;
        #1;
        check("cs_off_q8", q8, 8'hA5);
        rd_addr = 3'd7;
        #1;
        check("oob_q6", q6, 8'h00);
        step_clk();

        // Asynchronous reset between edges after four shifts.
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 1, 2'b01, 8'(8'h20 + i));
            step_clk();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count", count8, 0);
        check("async_newest", newest8, 8'h00);
        step_clk();
        #2;
        rst_n = 1'b1;
        set_in(0, 0, 1, 1, 2'b01, 8'h3C);
        step_clk();
        check("post_newest", newest8, 8'h3C);
        check("post_count", count8, 1);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom % 20) == 0, ($urandom % 25) == 0, ($urandom % 8) != 0,
                   ($urandom % 6) != 0, 2'($urandom), ($urandom % 2) ? 8'($urandom % 4) : 8'($urandom));
            rd_addr = 3'($urandom);
            cs = ($urandom % 5) == 0;
            step_clk();
        end

        set_in(0, 0, 0, 0, 2'b00, 8'h00);
        step_clk();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
